dram_portb_arbiter: RTL and testbench
=====================================

# dram_portb_arbiter

Round-robin arbiter that shares port B of the 128-bit shared system memory (the CPU-side AXI slave owns port A) between up to four accelerator requesters. It grants at most one single-beat access per cycle, drives the memory's port-B address/data/byte-write-enable, and tracks in-flight reads through the 2-cycle port-B read latency. Each read result is returned to the requester that issued it. A requester can hold a bounded burst lock so that its consecutive beats are not interleaved with other requesters.

## Interface
- NUM_REQ, 4, number of requesters (2..4)
- ADDR_W, 20, port-B word address width (128-bit words)
- RD_LAT, 2, port-B read latency in cycles; must match the memory's READ_LATENCY_B
- LOCK_MAX, 16, maximum consecutive locked beats before the lock is forcibly released

- pll_core_cpuclk  in  1  sole clock, rising edge
- pad_cpu_rst_b  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester access request
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero; combinational
- req_lock  in  NUM_REQ  keep grant after this beat
- req_wen  in  NUM_REQ*16  byte write enables; all-zero means read
- req_addr  in  NUM_REQ*ADDR_W  word address
- req_wdata  in  NUM_REQ*128  write data
- rsp_valid  out  NUM_REQ  read data valid, one-hot or zero, 1-cycle pulse
- rsp_data  out  128  read data, shared by all requesters
- dram1_portb_addr  out  ADDR_W  to memory port B
- dram1_portb_din  out  128  to memory port B
- dram1_portb_wen  out  16  to memory port B
- dram1_portb_dout  in  128  from memory port B; valid RD_LAT cycles after address

## Operation
- **Beat acceptance:** a beat from requester i is accepted when req_valid[i] && req_ready[i]. There is at most one accepted beat per cycle.
- **Unlocked arbitration:** round-robin. Search begins at pointer ptr and proceeds ptr, ptr+1, … mod NUM_REQ. The first valid requester is granted.
- **Pointer update:** after an accepted beat from i with req_lock[i]=0, ptr ← (i+1) mod NUM_REQ. A locked beat leaves ptr unchanged.
- **Entering lock:** an accepted beat with req_lock[i]=1 sets lock_active=1, lock_id=i and increments lock_cnt.
- **While locked:** only lock_id can be granted, and only when its req_valid is high. Other requesters see req_ready=0 even if lock_id is idle.
- **Lock release** (lock_active←0, lock_cnt←0, ptr←lock_id+1) happens when either:
  - lock_id has an accepted beat with req_lock=0, or
  - lock_cnt reaches LOCK_MAX on an accepted beat. This releases the lock regardless of req_lock, so the next cycle arbitrates normally.
- **Memory drive:**
  - On an accepted beat: dram1_portb_addr/din/wen come from the granted requester's slice.
  - Otherwise: dram1_portb_wen=0, addr and din=0.
- **Read tracking:**
  - An accepted beat with req_wen==0 pushes {1, id} into an RD_LAT-deep tag shift register; other cycles push {0, x}.
  - The last stage drives rsp_valid[id]=1 (one-hot).
  - rsp_data = dram1_portb_dout, passed through unregistered. The value is don't-care when no rsp_valid is high.
- **Writes** produce no response. Write completion is implied by acceptance.
- **Read-after-write:** reads and writes to the same address in back-to-back cycles are ordered by acceptance. The memory's port-B read-after-write behaviour applies unmodified.
- **Reset, including mid-operation:** ptr=0, lock_active=0, lock_cnt=0, tag pipeline cleared. In-flight reads are dropped and no rsp_valid fires for them.

## Timing
- **Reset values:** rsp_valid=0, dram1_portb_wen=0, addr=0, din=0. req_ready gives priority to requester 0.
- **req_ready:** combinational from req_valid and registered state. It does not depend on req_ready of any other block.
- **Read latency:** a read accepted in cycle T gives rsp_valid in cycle T+RD_LAT with rsp_data = memory output for that address. With RD_LAT=2 this is T+2.
- **Throughput:** one beat per cycle sustained. Back-to-back reads from different requesters return in acceptance order, one per cycle.
- **Counter widths:**
  - ptr: 2 bits, wraps at NUM_REQ−1 → 0.
  - lock_cnt: 5 bits, so it can count to LOCK_MAX=16.

## Test plan
- **Reset and single read:** after reset, req 0 reads addr 0x00010, which holds pattern 0xA5…A5. Expect req_ready[0]=1 in the same cycle, portb_addr=0x00010 and portb_wen=0, then rsp_valid=4'b0001 and rsp_data=0xA5…A5 exactly 2 cycles later.
- **Round-robin fairness:** all 4 requesters hold valid continuously for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3.
- **Mixed back-to-back traffic:** req 1 writes addr 5 with wen=0xFFFF and data 0x1234, then req 2 reads addr 5 in the next cycle. Expect rsp_valid=4'b0100 with data 0x1234, and no response pulse for the write.
- **Lock hold and release:** req 2 issues 3 locked beats then 1 unlocked beat while req 0 stays valid. Expect req_ready[0]=0 for those 4 beats, then req 0 granted next, with ptr=3 after release.
- **Lock timeout:** req 1 keeps req_lock=1 for 20 beats while req 3 is valid. Expect forced release after the 16th beat, then req 3 granted in the following cycle.
- **Reset mid-read:** assert pad_cpu_rst_b low 1 cycle after a read is accepted. Expect no rsp_valid for that read, and all outputs at reset values while reset is low.

Source files
------------

// File: rtl/dram_portb_arbiter.sv
// Port-B arbiter for the shared 128-bit system memory.
// Round-robin among up to four requesters, with a bounded burst lock.
// Read responses are steered back to the issuing requester after RD_LAT cycles.
module dram_portb_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 20,
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic                    pll_core_cpuclk,
  input  logic                    pad_cpu_rst_b,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ-1:0]      req_lock,
  input  logic [NUM_REQ*16-1:0]   req_wen,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*128-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [127:0]            rsp_data,
  output logic [ADDR_W-1:0]       dram1_portb_addr,
  output logic [127:0]            dram1_portb_din,
  output logic [15:0]             dram1_portb_wen,
  input  logic [127:0]            dram1_portb_dout
);

  localparam int ID_W  = 2;
  localparam int CNT_W = 5;

  logic [ID_W-1:0]  ptr;
  logic             lock_active;
  logic [ID_W-1:0]  lock_id;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  cand;
  logic [NUM_REQ-1:0] gnt;
  logic             beat_lock;
  logic             beat_read;

  logic [RD_LAT-1:0] tag_v;
  logic [ID_W-1:0]   tag_id [RD_LAT];

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ-1)) ? '0 : x + 1'b1;
  endfunction

  // Pick the winner: the lock owner only while locked, otherwise first valid from ptr upward.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = ptr;
    if (lock_active) begin
      gnt_any = req_valid[lock_id];
      gnt_id  = lock_id;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_id  = cand;
        end
        cand = next_id(cand);
      end
    end
  end

  // One-hot grant and memory port mux; port idles at zero when nothing is accepted.
  always_comb begin
    gnt              = '0;
    dram1_portb_wen  = '0;
    dram1_portb_addr = '0;
    dram1_portb_din  = '0;
    beat_lock        = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && (gnt_id == ID_W'(i))) begin
        gnt[i]           = 1'b1;
        dram1_portb_wen  = req_wen[i*16 +: 16];
        dram1_portb_addr = req_addr[i*ADDR_W +: ADDR_W];
        dram1_portb_din  = req_wdata[i*128 +: 128];
        beat_lock        = req_lock[i];
      end
    end
  end

  assign req_ready = gnt;
  assign beat_read = gnt_any && (dram1_portb_wen == '0);
  assign cnt_nxt   = (lock_active ? lock_cnt : '0) + 1'b1;

  // Pointer and lock state; a lock ends on an unlocked beat or when the beat count hits LOCK_MAX.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      ptr         <= '0;
      lock_active <= 1'b0;
      lock_id     <= '0;
      lock_cnt    <= '0;
    end else if (gnt_any) begin
      if (beat_lock && (cnt_nxt < CNT_W'(LOCK_MAX))) begin
        lock_active <= 1'b1;
        lock_id     <= gnt_id;
        lock_cnt    <= cnt_nxt;
      end else begin
        lock_active <= 1'b0;
        lock_cnt    <= '0;
        ptr         <= next_id(gnt_id);
      end
    end
  end

  // Read tag pipeline, aligned with the memory's read latency.
  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      tag_v <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= beat_read;
      tag_id[0] <= gnt_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // Steer the returning read to its issuer; data is the raw memory output.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = tag_v[RD_LAT-1] && (tag_id[RD_LAT-1] == ID_W'(i));
  end

  assign rsp_data = dram1_portb_dout;

endmodule

// File: tb/tb_dram_portb_arbiter.sv
// Self-checking bench for dram_portb_arbiter with a behavioural memory and reference model.
module tb_dram_portb_arbiter;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int RL = 2;
  localparam int LM = 16;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      valid, lock, ready, rspv;
  logic [N*16-1:0]   wen;
  logic [N*AW-1:0]   addr;
  logic [N*128-1:0]  wdata;
  logic [127:0]      rdata, pb_din, pb_dout;
  logic [AW-1:0]     pb_addr;
  logic [15:0]       pb_wen;

  dram_portb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .RD_LAT(RL), .LOCK_MAX(LM)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst_b   (rst_b),
    .req_valid       (valid),
    .req_ready       (ready),
    .req_lock        (lock),
    .req_wen         (wen),
    .req_addr        (addr),
    .req_wdata       (wdata),
    .rsp_valid       (rspv),
    .rsp_data        (rdata),
    .dram1_portb_addr(pb_addr),
    .dram1_portb_din (pb_din),
    .dram1_portb_wen (pb_wen),
    .dram1_portb_dout(pb_dout)
  );

  // Behavioural port-B memory: two-cycle read latency, byte writes.
  logic [127:0] mem [256];
  logic [127:0] d1, wtmp;
  always @(posedge clk) begin
    d1      <= mem[pb_addr[7:0]];
    pb_dout <= d1;
    wtmp = mem[pb_addr[7:0]];
    for (int b = 0; b < 16; b++)
      if (pb_wen[b]) wtmp[b*8 +: 8] = pb_din[b*8 +: 8];
    if (pb_wen != 16'h0) mem[pb_addr[7:0]] <= wtmp;
  end

  // Reference model state
  typedef struct {
    int           due;
    int           id;
    logic [127:0] data;
  } rsp_t;
  rsp_t         q[$];
  logic [127:0] ref_mem [256];
  int m_ptr, m_lock, m_lock_id, m_cnt, cyc;
  int npass = 0, nfail = 0, ntotal = 0;
  logic [N-1:0] o_ready, o_rspv;
  logic [127:0] o_rdata;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_lock = 0; m_lock_id = 0; m_cnt = 0;
    q.delete();
  endfunction

  function automatic int exp_grant();
    if (m_lock != 0) return valid[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < N; k++)
      if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic void model_accept(input int g);
    rsp_t r;
    int a;
    a = int'(addr[g*AW +: 8]);
    if (wen[g*16 +: 16] == 16'h0) begin
      r.due = cyc + RL; r.id = g; r.data = ref_mem[a];
      q.push_back(r);
    end else begin
      for (int b = 0; b < 16; b++)
        if (wen[g*16 + b]) ref_mem[a][b*8 +: 8] = wdata[g*128 + b*8 +: 8];
    end
    if (lock[g]) begin
      m_cnt++;
      if (m_cnt >= LM) begin
        m_lock = 0; m_cnt = 0; m_ptr = (g + 1) % N;
      end else begin
        m_lock = 1; m_lock_id = g;
      end
    end else begin
      m_lock = 0; m_cnt = 0; m_ptr = (g + 1) % N;
    end
  endfunction

  // One cycle: settle, compare against model, clock, advance model.
  task automatic step();
    int g;
    logic [N-1:0] ev, erv;
    logic [15:0] ew;
    logic [AW-1:0] ea;
    logic [127:0] ed;
    #3;
    if (!rst_b) model_reset();
    g = exp_grant();
    ev = '0; ew = '0; ea = '0; ed = '0;
    if (g >= 0) begin
      ev[g] = 1'b1;
      ew = wen[g*16 +: 16];
      ea = addr[g*AW +: AW];
      ed = wdata[g*128 +: 128];
    end
    chk("req_ready", ready, ev);
    chk("portb_wen", pb_wen, ew);
    chk("portb_addr", pb_addr, ea);
    chk("portb_din", pb_din, ed);
    erv = '0;
    if (q.size() > 0 && q[0].due == cyc) erv[q[0].id] = 1'b1;
    chk("rsp_valid", rspv, erv);
    if (erv != '0) chk("rsp_data", rdata, q[0].data);
    o_ready = ready; o_rspv = rspv; o_rdata = rdata;
    @(posedge clk);
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    if (rst_b && g >= 0) model_accept(g);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    valid = '0; lock = '0; wen = '0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_b = 1'b0;
    step();
    step();
    rst_b = 1'b1;
  endtask

  initial begin
    idle_inputs();
    cyc = 0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = {16{8'hA5}};
    ref_mem[8'h10] = {16{8'hA5}};
    @(posedge clk); #1;

    // Reset and single read
    do_reset();
    valid = 4'b0001; addr[0 +: AW] = 20'h00010;
    step();
    chk("t1_ready", o_ready, 4'b0001);
    idle_inputs();
    step();
    step();
    chk("t1_rsp_valid", o_rspv, 4'b0001);
    chk("t1_rsp_data", o_rdata, {16{8'hA5}});

    // Round-robin fairness
    do_reset();
    valid = 4'b1111;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(i + 32);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_order", o_ready, 4'b0001 << (k % 4));
    end
    idle_inputs();
    step(); step();

    // Write then read same address, back to back
    valid = 4'b0010; wen[16 +: 16] = 16'hFFFF; addr[AW +: AW] = 20'd5; wdata[128 +: 128] = 128'h1234;
    step();
    idle_inputs();
    valid = 4'b0100; addr[2*AW +: AW] = 20'd5;
    step();
    chk("raw_rd_ready", o_ready, 4'b0100);
    idle_inputs();
    step();
    chk("raw_no_wr_rsp", o_rspv, 4'b0000);
    step();
    chk("raw_rsp_valid", o_rspv, 4'b0100);
    chk("raw_rsp_data", o_rdata, 128'h1234);

    // Lock hold and release
    do_reset();
    valid = 4'b0010;
    step();
    valid = 4'b0101; lock = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) lock = 4'b0000;
      step();
      chk("lock_hold", o_ready, 4'b0100);
    end
    step();
    chk("lock_after_release", o_ready, 4'b0001);
    idle_inputs();
    step(); step();

    // Lock timeout
    do_reset();
    valid = 4'b1010; lock = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k < 16) chk("timeout_hold", o_ready, 4'b0010);
      else if (k == 16) chk("timeout_release", o_ready, 4'b1000);
    end
    idle_inputs();
    step(); step();

    // Reset mid-read
    do_reset();
    valid = 4'b0001; addr[0 +: AW] = 20'h00010;
    step();
    idle_inputs();
    rst_b = 1'b0;
    step();
    step();
    chk("rst_mid_rsp", o_rspv, 4'b0000);
    step();
    rst_b = 1'b1;
    step();
    chk("rst_after_rsp", o_rspv, 4'b0000);
    step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        lock[i] = ((c / 50) % 3 == 2) ? 1'b1 : ($urandom_range(0, 3) == 0);
        wen[i*16 +: 16] = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
        addr[i*AW +: AW] = AW'($urandom_range(0, 15));
        wdata[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    idle_inputs();
    step(); step(); step();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
